// File: rtl/multicycle_controller.sv
// multicycle_controller
// Sequencing FSM for a multicycle RV32I datapath that shares one memory and
// one ALU. Each instruction moves through fetch, decode, execute, memory and
// writeback states. The controller drives the datapath mux selects, register
// enables and ALU function code. It stalls on the memory ready handshake,
// traps on unsupported opcodes and counts retired instructions.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   op, funct3, funct7b5  instruction fields taken from the instruction register
//   Zero                  ALU zero flag, used to qualify the beq PC update
//   mem_ready             memory completes the current access this cycle
//   mem_req, MemWrite     memory request and write strobe
//   PCWrite, IRWrite      PC and instruction/OldPC register enables
//   RegWrite              register file write enable
//   AdrSrc                memory address select (0=PC, 1=Result)
//   ResultSrc             00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA               00=PC, 01=OldPC, 10=A
//   ALUSrcB               00=B, 01=ImmExt, 10=4
//   ImmSrc                00=I, 01=S, 10=B, 11=J
//   ALUControl            ALU function code
//   illegal               sticky trap flag
//   state                 current FSM state, for debug
//   instr_count           retired instruction count, wraps modulo 2^CNT_W
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [3:0]       ALUControl,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU decode: aluop 00 = add, 01 = subtract, 10 = funct3-driven operation
  function automatic logic [3:0] alu_decode(input logic [1:0] aluop,
                                            input logic [2:0] f3,
                                            input logic       op5,
                                            input logic       f7b5);
    logic [3:0] ctl;
    ctl = 4'b0000;
    case (aluop)
      2'b00: ctl = 4'b0000;
      2'b01: ctl = 4'b0001;
      2'b10: begin
        case (f3)
          // funct7b5 only means subtract on R-type; addi reuses that bit as immediate
          3'b000:  ctl = (op5 & f7b5) ? 4'b0001 : 4'b0000;
          3'b001:  ctl = 4'b0110;
          3'b010:  ctl = 4'b0101;
          3'b011:  ctl = 4'b1001;
          3'b100:  ctl = 4'b0100;
          3'b101:  ctl = f7b5 ? 4'b1000 : 4'b0111;
          3'b110:  ctl = 4'b0011;
          3'b111:  ctl = 4'b0010;
          default: ctl = 4'b0000;
        endcase
      end
      default: ctl = 4'b0000;
    endcase
    return ctl;
  endfunction

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       mem_req_s, pc_write_s, ir_write_s, mem_write_s, reg_write_s;
  logic       adr_src_s;
  logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s;

  // Next-state and Moore output decode
  always_comb begin
    state_d      = state_q;
    mem_req_s    = 1'b0;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = mem_ready;
        pc_write_s   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        if (op == OP_LOAD) state_d = S_MEMREAD;
        else               state_d = S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else           state_d = S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        adr_src_s   = 1'b1;
        mem_write_s = mem_ready;
        if (mem_ready) state_d = S_FETCH;
        else           state_d = S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        pc_write_s  = Zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // ALUResult = OldPC + 4 is the link value; ALUOut holds the target
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      // Unreachable encodings fail safe into the trap state
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // Sticky trap flag and retire counter next values
  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Immediate format select follows the opcode, independent of state
  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  // State, trap flag and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Strobes are gated by rst_n so nothing fires while reset is held
  assign mem_req     = mem_req_s   & rst_n;
  assign PCWrite     = pc_write_s  & rst_n;
  assign IRWrite     = ir_write_s  & rst_n;
  assign MemWrite    = mem_write_s & rst_n;
  assign RegWrite    = reg_write_s & rst_n;
  assign AdrSrc      = adr_src_s;
  assign ResultSrc   = result_src_s;
  assign ALUSrcA     = alu_src_a_s;
  assign ALUSrcB     = alu_src_b_s;
  assign ALUControl  = alu_decode(alu_op_s, funct3, op[5], funct7b5);
  assign illegal     = illegal_q;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed testbench for multicycle_controller. Each task drives one scenario
// and compares the DUT outputs against hand-computed expected values. Outputs
// are sampled shortly after the rising edge, once inputs have settled.
module tb_multicycle_controller;

  logic        clk;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        mem_ready;
  logic        mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0]  ALUControl;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int checks;
  int failures;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal(illegal), .state(state),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    Zero = 1'b0; mem_ready = 1'b1;
    #3;
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
    checks++; if ({mem_req, PCWrite, IRWrite, MemWrite, RegWrite} !== 5'b00000) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", {mem_req, PCWrite, IRWrite, MemWrite, RegWrite}); end
    checks++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 6'b001010) begin failures++; $display("FAIL reset_fetch_decode got=%b exp=001010", {ALUSrcA, ALUSrcB, ResultSrc}); end
    mem_ready = 1'b0;
    rst_n = 1'b1;
    step();
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL fetch_hold_state got=%0d exp=0", state); end
    checks++; if ({mem_req, IRWrite, PCWrite, AdrSrc} !== 4'b1000) begin failures++; $display("FAIL fetch_hold_outs got=%b exp=1000", {mem_req, IRWrite, PCWrite, AdrSrc}); end
  endtask

  task automatic test_add();
    int exp_st[5] = '{0, 1, 6, 8, 0};
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
    #1;
    checks++; if ({IRWrite, PCWrite} !== 2'b11) begin failures++; $display("FAIL add_fetch_strobes got=%b exp=11", {IRWrite, PCWrite}); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (state !== exp_st[i][3:0]) begin failures++; $display("FAIL add_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
      checks++; if (RegWrite !== (exp_st[i] == 8)) begin failures++; $display("FAIL add_regwrite[%0d] got=%b exp=%b", i, RegWrite, exp_st[i] == 8); end
      if (exp_st[i] == 6) begin
        checks++; if (ALUControl !== 4'b0000) begin failures++; $display("FAIL add_aluctl got=%b exp=0000", ALUControl); end
        checks++; if ({ALUSrcA, ALUSrcB} !== 4'b1000) begin failures++; $display("FAIL add_srcs got=%b exp=1000", {ALUSrcA, ALUSrcB}); end
      end
      if (i < 4) step();
    end
    checks++; if (instr_count !== 32'd1) begin failures++; $display("FAIL add_count got=%0d exp=1", instr_count); end
  endtask

  task automatic test_sub_srai();
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; mem_ready = 1'b1;
    step(); step();
    checks++; if (state !== 4'd6) begin failures++; $display("FAIL sub_state got=%0d exp=6", state); end
    checks++; if (ALUControl !== 4'b0001) begin failures++; $display("FAIL sub_aluctl got=%b exp=0001", ALUControl); end
    step(); step();
    op = 7'b0010011; funct3 = 3'b101; funct7b5 = 1'b1;
    step(); step();
    checks++; if (state !== 4'd7) begin failures++; $display("FAIL srai_state got=%0d exp=7", state); end
    checks++; if (ALUControl !== 4'b1000) begin failures++; $display("FAIL srai_aluctl got=%b exp=1000", ALUControl); end
    checks++; if ({ALUSrcA, ALUSrcB} !== 4'b1001) begin failures++; $display("FAIL srai_srcs got=%b exp=1001", {ALUSrcA, ALUSrcB}); end
    funct3 = 3'b000; #1;
    checks++; if (ALUControl !== 4'b0000) begin failures++; $display("FAIL addi_f7_aluctl got=%b exp=0000", ALUControl); end
    step(); step();
    checks++; if (state !== 4'd0 || instr_count !== 32'd3) begin failures++; $display("FAIL srai_retire got=%0d/%0d exp=0/3", state, instr_count); end
  endtask

  task automatic test_lw_stall();
    int exp_st[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
    logic [7:0] mr = 8'b11100111;  // bit i = mem_ready in cycle i, low in MEMREAD cycles 3..4
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[7-i];
      #1;
      checks++; if (state !== exp_st[i][3:0]) begin failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
      if (exp_st[i] == 3) begin
        checks++; if ({mem_req, AdrSrc, MemWrite, RegWrite} !== 4'b1100) begin failures++; $display("FAIL lw_memread[%0d] got=%b exp=1100", i, {mem_req, AdrSrc, MemWrite, RegWrite}); end
      end
      if (exp_st[i] == 4) begin
        checks++; if ({ResultSrc, RegWrite} !== 3'b011) begin failures++; $display("FAIL lw_memwb got=%b exp=011", {ResultSrc, RegWrite}); end
      end
      if (i < 7) step();
    end
    checks++; if (instr_count !== 32'd4) begin failures++; $display("FAIL lw_count got=%0d exp=4", instr_count); end
  endtask

  task automatic test_sw();
    op = 7'b0100011; mem_ready = 1'b1;
    #1;
    checks++; if (ImmSrc !== 2'b01) begin failures++; $display("FAIL sw_immsrc got=%b exp=01", ImmSrc); end
    step(); step(); step();
    checks++; if (state !== 4'd5) begin failures++; $display("FAIL sw_state got=%0d exp=5", state); end
    checks++; if ({mem_req, AdrSrc, MemWrite} !== 3'b111) begin failures++; $display("FAIL sw_strobes got=%b exp=111", {mem_req, AdrSrc, MemWrite}); end
    step();
    checks++; if (state !== 4'd0 || instr_count !== 32'd5) begin failures++; $display("FAIL sw_retire got=%0d/%0d exp=0/5", state, instr_count); end
  endtask

  task automatic test_beq();
    logic [1:0] zv = 2'b10;
    op = 7'b1100011; mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      Zero = zv[1-k];
      step();
      checks++; if (PCWrite !== 1'b0 || ImmSrc !== 2'b10) begin failures++; $display("FAIL beq_decode[%0d] got=%b/%b exp=0/10", k, PCWrite, ImmSrc); end
      step();
      checks++; if (state !== 4'd9) begin failures++; $display("FAIL beq_state[%0d] got=%0d exp=9", k, state); end
      checks++; if (PCWrite !== zv[1-k]) begin failures++; $display("FAIL beq_pcwrite[%0d] got=%b exp=%b", k, PCWrite, zv[1-k]); end
      checks++; if (ALUControl !== 4'b0001) begin failures++; $display("FAIL beq_aluctl[%0d] got=%b exp=0001", k, ALUControl); end
      step();
      checks++; if (state !== 4'd0) begin failures++; $display("FAIL beq_return[%0d] got=%0d exp=0", k, state); end
    end
    Zero = 1'b0;
    checks++; if (instr_count !== 32'd7) begin failures++; $display("FAIL beq_count got=%0d exp=7", instr_count); end
  endtask

  task automatic test_jal();
    op = 7'b1101111; mem_ready = 1'b1;
    step(); step();
    checks++; if (state !== 4'd10) begin failures++; $display("FAIL jal_state got=%0d exp=10", state); end
    checks++; if ({PCWrite, ALUSrcA, ALUSrcB, ImmSrc} !== 7'b1011011) begin failures++; $display("FAIL jal_outs got=%b exp=1011011", {PCWrite, ALUSrcA, ALUSrcB, ImmSrc}); end
    step();
    checks++; if (state !== 4'd8 || RegWrite !== 1'b1) begin failures++; $display("FAIL jal_wb got=%0d/%b exp=8/1", state, RegWrite); end
    step();
    checks++; if (state !== 4'd0 || instr_count !== 32'd8) begin failures++; $display("FAIL jal_retire got=%0d/%0d exp=0/8", state, instr_count); end
  endtask

  task automatic test_trap();
    op = 7'b1110011; mem_ready = 1'b1;
    step(); step();
    checks++; if (state !== 4'd11 || illegal !== 1'b1) begin failures++; $display("FAIL trap_entry got=%0d/%b exp=11/1", state, illegal); end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (state !== 4'd11 || {mem_req, PCWrite, IRWrite, MemWrite, RegWrite} !== 5'b00000 || instr_count !== 32'd8) begin
        failures++;
        $display("FAIL trap_hold[%0d] state=%0d strobes=%b count=%0d exp=11/00000/8", i, state, {mem_req, PCWrite, IRWrite, MemWrite, RegWrite}, instr_count);
      end
    end
  endtask

  task automatic test_reset_mid_memread();
    rst_n = 1'b0; #1; rst_n = 1'b1; #1;
    checks++; if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== 32'd0) begin failures++; $display("FAIL trap_exit got=%0d/%b/%0d exp=0/0/0", state, illegal, instr_count); end
    op = 7'b0000011; mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    step(); step();
    checks++; if (state !== 4'd3) begin failures++; $display("FAIL mid_memread_state got=%0d exp=3", state); end
    rst_n = 1'b0; #1;
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL mid_reset_state got=%0d exp=0", state); end
    checks++; if ({mem_req, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc} !== 6'b000000) begin failures++; $display("FAIL mid_reset_outs got=%b exp=000000", {mem_req, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc}); end
    rst_n = 1'b1; mem_ready = 1'b1; #1;
    checks++; if (state !== 4'd0 || IRWrite !== 1'b1) begin failures++; $display("FAIL release_fetch got=%0d/%b exp=0/1", state, IRWrite); end
    step();
    checks++; if (state !== 4'd1) begin failures++; $display("FAIL release_decode got=%0d exp=1", state); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_sub_srai();
    test_lw_stall();
    test_sw();
    test_beq();
    test_jal();
    test_trap();
    test_reset_mid_memread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle RV32I datapath: one shared memory, one ALU, instruction/data/ALU-out registers.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects, register write enables and ALU function codes.
- Stalls on a memory ready handshake, traps on unsupported opcodes and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  opcode from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=Result
IRWrite  out  1  instruction/OldPC register enable
MemWrite  out  1  memory write strobe
RegWrite  out  1  register file write enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=A(rs1)
ALUSrcB  out  2  00=B(rs2), 01=ImmExt, 10=constant 4
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
ALUControl  out  4  ALU function
illegal  out  1  sticky trap flag
state  out  4  current state, for debug
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (rst_n low, async) sets state to FETCH, clears illegal and instr_count.
- While rst_n is low, mem_req, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. All other outputs take their FETCH decode.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Outputs are Moore decodes of state, except where a strobe is gated by mem_ready or Zero as noted. Unlisted strobes are 0.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
  - 0000011 or 0100011: MEMADR
  - 0110011: EXECR
  - 0010011: EXECI
  - 1100011: BEQ
  - 1101111: JAL
  - otherwise: TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Holds until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00, MemWrite=mem_ready. Holds until mem_ready, then goes to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero. Goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Goes to ALUWB.
- TRAP: illegal set to 1, all strobes 0, mem_req 0. Exits only on reset.
- ImmSrc is combinational on op, independent of state:
  - 0100011: 01
  - 1100011: 10
  - 1101111: 11
  - else: 00
- ALUControl encoding: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLL=0110, SRL=0111, SRA=1000, SLTU=1001.
- ALUOp=00 gives ADD. ALUOp=01 gives SUB. ALUOp=10 decodes funct3:
  - 000: SUB if op[5]&funct7b5, else ADD
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRA if funct7b5, else SRL
  - 110: OR
  - 111: AND
- instr_count increments by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from any other state. TRAP entry does not count.
- Cycle counts with mem_ready held at 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
- Each cycle mem_ready is low in a memory state adds one cycle.
- mem_ready high outside memory states is ignored.

Test Plan:
- Reset mid-MEMREAD with mem_ready=0: state goes to 0 immediately, strobes are 0 while rst_n is low, and FETCH resumes on the first edge after release.
- add (op=0110011, funct3=000, funct7b5=0), mem_ready=1: state sequence 0,1,6,8,0 with ALUControl=0000 in EXECR, RegWrite=1 only in ALUWB, instr_count goes 0 to 1.
- sub then srai (funct3=101, funct7b5=1): ALUControl=0001 in EXECR for sub, then 1000 in EXECI for srai.
- lw with mem_ready low for 2 cycles in MEMREAD: MEMREAD lasts 3 cycles with AdrSrc=1 and mem_req=1 throughout, total latency 7 cycles, ResultSrc=01 in MEMWB.
- beq with Zero=1 then with Zero=0: PCWrite pulses 1 cycle in BEQ only when Zero=1, and ALUControl=0001 in both cases.
- op=1110011 in DECODE: goes to state 11, illegal=1, no strobes for 20 cycles, instr_count frozen.
